inst_fetch_queue: RTL and testbench

Parametrised instruction-fetch unit that replaces the single-entry fetch stage. It issues PCs to the I-cache one request at a time and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It presents the FIFO head to issue under a valid/ready handshake and stalls fetch when the FIFO has no reserved space. On a redirect it flushes the FIFO and discards any stale in-flight I-cache response.

---
 rtl/inst_fetch_queue_pkg.sv | 17 +
 rtl/inst_fetch_queue_if.sv | 42 ++++
 rtl/inst_fetch_queue_if_fifo.sv | 67 ++++++
 rtl/inst_fetch_queue.sv | 135 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and FSM state encoding for the instruction-fetch queue.
package inst_fetch_queue_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic HIGH  = 1'b1;
  localparam logic LOW   = 1'b0;

  // IF_DRAIN: a redirect arrived while a request was in flight; the
  // response still has to be absorbed before a new request may go out.
  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_WAIT  = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between the fetch queue, the I-cache and the issue stage.
// master: the fetch queue itself. slave: the I-cache/issue side.
interface inst_fetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32
);

  // I-cache request/response
  logic                  pc_send_enable;
  logic [ADDR_WIDTH-1:0] pc_to_ic;
  logic                  inst_get_ready;
  logic [INST_WIDTH-1:0] inst_from_ic;

  // Issue-side valid/ready
  logic                  inst_valid;
  logic [INST_WIDTH-1:0] inst_to_issue;
  logic [ADDR_WIDTH-1:0] pc_to_issue;
  logic                  issue_ready;

  modport master (
    output pc_send_enable,
    output pc_to_ic,
    input  inst_get_ready,
    input  inst_from_ic,
    output inst_valid,
    output inst_to_issue,
    output pc_to_issue,
    input  issue_ready
  );

  modport slave (
    input  pc_send_enable,
    input  pc_to_ic,
    output inst_get_ready,
    output inst_from_ic,
    input  inst_valid,
    input  inst_to_issue,
    input  pc_to_issue,
    output issue_ready
  );

endinterface

// File: rtl/inst_fetch_queue_if_fifo.sv
// Parametrised synchronous FIFO holding {instruction, pc} pairs.
// Flush has priority over push/pop; a pop of an empty FIFO is ignored.
module if_fifo #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  input  logic                 flush,
  output logic [WIDTH-1:0]     head_data,
  output logic [DEPTH_LOG:0]   count
);

  localparam int unsigned       DEPTH     = 1 << DEPTH_LOG;
  localparam int unsigned       PTR_W     = (DEPTH_LOG > 0) ? DEPTH_LOG : 1;
  localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [DEPTH_LOG:0] count_q;
  logic             do_pop;
  logic             do_push;

  // Explicit wrap keeps the pointer logic valid for a single-entry FIFO too.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != DEPTH_CNT) || do_pop);

  assign head_data = mem[head_q];
  assign count     = count_q;

  // Storage write; no reset needed, occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      mem[tail_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= bump(tail_q);
      if (do_pop)  head_q <= bump(head_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Space is reserved before a request is issued, so this must never fire.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !do_pop && (count_q == DEPTH_CNT)));

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch unit: issues one PC at a time to the I-cache, buffers
// returned instructions with their PCs, and presents the oldest to issue.
// Redirects flush the queue and swallow any response still in flight.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter int unsigned           DEPTH_LOG  = 3,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           PC_STEP    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  inst_fetch_queue_if.master     bus,
  input  logic                   jump_flag,
  input  logic [ADDR_WIDTH-1:0]  target_pc,
  output logic [DEPTH_LOG:0]     queue_count
);

  localparam int unsigned        DEPTH     = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG + 1)'(DEPTH);
  localparam int unsigned        ENTRY_W   = INST_WIDTH + ADDR_WIDTH;

  if_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_to_ic_q, pc_to_ic_d;
  logic                  send_q, send_d;

  logic                  jump;
  logic                  resp;
  logic                  pop;
  logic                  push;
  logic [DEPTH_LOG:0]    count;
  logic [DEPTH_LOG:0]    count_after_pop;
  logic [ENTRY_W-1:0]    head_data;

  assign jump = rdy && jump_flag;
  assign resp = rdy && bus.inst_get_ready;
  assign pop  = rdy && (count != '0) && bus.issue_ready;

  // Occupancy once this cycle's pop has been taken into account; a request
  // only goes out if the slot for its response is already guaranteed.
  assign count_after_pop = count - {{DEPTH_LOG{1'b0}}, pop};

  // Next-state, PC and request-register logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_to_ic_d = pc_to_ic_q;
    send_d     = send_q;
    push       = FALSE;
    if (rdy) begin
      case (state_q)
        IF_IDLE: begin
          if (jump) begin
            pc_d   = target_pc;
            send_d = LOW;
          end else if (count_after_pop < DEPTH_CNT) begin
            pc_to_ic_d = pc_q;
            send_d     = HIGH;
            state_d    = IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (jump) begin
            pc_d = target_pc;
            if (resp) begin
              send_d  = LOW;
              state_d = IF_IDLE;
            end else begin
              state_d = IF_DRAIN;
            end
          end else if (resp) begin
            push    = TRUE;
            pc_d    = pc_q + ADDR_WIDTH'(PC_STEP);
            send_d  = LOW;
            state_d = IF_IDLE;
          end
        end
        IF_DRAIN: begin
          // A response coinciding with a further redirect still retires the
          // stale request, otherwise the FSM would wait for a second answer.
          if (jump) pc_d = target_pc;
          if (resp) begin
            send_d  = LOW;
            state_d = IF_IDLE;
          end
        end
        default: begin
          send_d  = LOW;
          state_d = IF_IDLE;
        end
      endcase
    end
  end

  // State, PC and request registers; frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IF_IDLE;
      pc_q       <= RESET_PC;
      pc_to_ic_q <= '0;
      send_q     <= LOW;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_to_ic_q <= pc_to_ic_d;
      send_q     <= send_d;
    end
  end

  if_fifo #(
    .WIDTH     (ENTRY_W),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bus.inst_from_ic, pc_q}),
    .pop       (pop),
    .flush     (jump),
    .head_data (head_data),
    .count     (count)
  );

  assign bus.pc_send_enable = send_q;
  assign bus.pc_to_ic       = pc_to_ic_q;
  assign bus.inst_valid     = (count != '0);
  assign bus.pc_to_issue    = head_data[ADDR_WIDTH-1:0];
  assign bus.inst_to_issue  = head_data[ENTRY_W-1:ADDR_WIDTH];
  assign queue_count        = count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a cycle table for the basic fetch
// stream, then hand-written sequences for freeze, redirect, reset and wrap.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        jump_flag;
  logic [31:0] target_pc;
  logic [3:0]  qc_m;

  logic        rst_s;
  logic        rdy_s;
  logic        jump_s;
  logic [31:0] target_s;
  logic [2:0]  qc_s;

  int checks;
  int errors;
  int exp_k;
  logic auto_ic;
  logic sb_on;

  inst_fetch_queue_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) m_bus ();
  inst_fetch_queue_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) s_bus ();

  inst_fetch_queue #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .DEPTH_LOG  (3),
    .RESET_PC   (32'h0),
    .PC_STEP    (4)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .bus         (m_bus),
    .jump_flag   (jump_flag),
    .target_pc   (target_pc),
    .queue_count (qc_m)
  );

  inst_fetch_queue #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .DEPTH_LOG  (2),
    .RESET_PC   (32'h0),
    .PC_STEP    (4)
  ) u_small (
    .clk         (clk),
    .rst         (rst_s),
    .rdy         (rdy_s),
    .bus         (s_bus),
    .jump_flag   (jump_s),
    .target_pc   (target_s),
    .queue_count (qc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: score a pop on the main DUT, advance, then update responders.
  task automatic cycle();
    logic [31:0] epc;
    if (sb_on && m_bus.inst_valid && m_bus.issue_ready && rdy && !jump_flag) begin
      epc = 32'hFFFF_FFF0 + 32'(4 * exp_k);
      chk("wrap_pc", m_bus.pc_to_issue, epc);
      chk("wrap_inst", m_bus.inst_to_issue, f(epc));
      exp_k++;
    end
    @(posedge clk);
    #1;
    if (auto_ic) begin
      if (m_bus.inst_get_ready) begin
        m_bus.inst_get_ready = 1'b0;
      end else if (m_bus.pc_send_enable && ($urandom_range(0, 1) == 1)) begin
        m_bus.inst_get_ready = 1'b1;
        m_bus.inst_from_ic   = f(m_bus.pc_to_ic);
      end
    end
    if (s_bus.inst_get_ready) begin
      s_bus.inst_get_ready = 1'b0;
    end else if (s_bus.pc_send_enable) begin
      s_bus.inst_get_ready = 1'b1;
      s_bus.inst_from_ic   = f(s_bus.pc_to_ic);
    end
  endtask

  task automatic step(input logic igr, input logic [31:0] d, input logic ir,
                      input logic jmp, input logic [31:0] tgt);
    m_bus.inst_get_ready = igr;
    m_bus.inst_from_ic   = d;
    m_bus.issue_ready    = ir;
    jump_flag            = jmp;
    target_pc            = tgt;
    cycle();
  endtask

  typedef struct {
    logic        igr;
    logic [31:0] data;
    logic        ir;
    logic        pse;
    logic [31:0] pcic;
    logic        valid;
    logic [31:0] pti;
    logic [31:0] qc;
  } vec_t;

  vec_t vt [10];

  initial begin
    checks = 0;
    errors = 0;
    exp_k  = 0;
    auto_ic = 1'b0;
    sb_on   = 1'b0;
    rst = 1'b1; rdy = 1'b1; jump_flag = 1'b0; target_pc = '0;
    rst_s = 1'b1; rdy_s = 1'b1; jump_s = 1'b0; target_s = '0;
    m_bus.inst_get_ready = 1'b0; m_bus.inst_from_ic = '0; m_bus.issue_ready = 1'b0;
    s_bus.inst_get_ready = 1'b0; s_bus.inst_from_ic = '0; s_bus.issue_ready = 1'b0;

    // I-cache answers two cycles after each request, issue always ready.
    vt[0] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'd0};
    vt[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'd0};
    vt[2] = '{1'b1, f(32'h0), 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'd1};
    vt[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'd0};
    vt[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'd0};
    vt[5] = '{1'b1, f(32'h4), 1'b1, 1'b0, 32'h4, 1'b1, 32'h4, 32'd1};
    vt[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'd0};
    vt[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'd0};
    vt[8] = '{1'b1, f(32'h8), 1'b1, 1'b0, 32'h8, 1'b1, 32'h8, 32'd1};
    vt[9] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hC, 1'b1, 32'h8, 32'd1};

    cycle();
    cycle();
    chk("rst_pse", 32'(m_bus.pc_send_enable), 32'd0);
    chk("rst_pcic", m_bus.pc_to_ic, 32'h0);
    chk("rst_valid", 32'(m_bus.inst_valid), 32'd0);
    chk("rst_qc", 32'(qc_m), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(vt[i].igr, vt[i].data, vt[i].ir, 1'b0, 32'h0);
      chk($sformatf("v%0d_pse", i), 32'(m_bus.pc_send_enable), 32'(vt[i].pse));
      chk($sformatf("v%0d_pcic", i), m_bus.pc_to_ic, vt[i].pcic);
      chk($sformatf("v%0d_valid", i), 32'(m_bus.inst_valid), 32'(vt[i].valid));
      chk($sformatf("v%0d_qc", i), 32'(qc_m), vt[i].qc);
      if (vt[i].valid) begin
        chk($sformatf("v%0d_pti", i), m_bus.pc_to_issue, vt[i].pti);
        chk($sformatf("v%0d_inst", i), m_bus.inst_to_issue, f(vt[i].pti));
      end
    end

    // rdy low mid-WAIT: responses, pops and a jump must all be ignored.
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step((k % 2) == 0, 32'hBAD0_0000 + 32'(k), 1'b1, k == 3, 32'h300);
      chk("frz_pse", 32'(m_bus.pc_send_enable), 32'd1);
      chk("frz_pcic", m_bus.pc_to_ic, 32'hC);
      chk("frz_qc", 32'(qc_m), 32'd1);
      chk("frz_pti", m_bus.pc_to_issue, 32'h8);
    end
    rdy = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("thaw_pse", 32'(m_bus.pc_send_enable), 32'd1);
    chk("thaw_qc", 32'(qc_m), 32'd1);
    step(1'b1, f(32'hC), 1'b0, 1'b0, 32'h0);
    chk("thaw_push_qc", 32'(qc_m), 32'd2);
    chk("thaw_push_pse", 32'(m_bus.pc_send_enable), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("thaw_pop_qc", 32'(qc_m), 32'd1);
    chk("thaw_pop_pti", m_bus.pc_to_issue, 32'hC);
    chk("thaw_pop_inst", m_bus.inst_to_issue, f(32'hC));
    chk("thaw_pcic", m_bus.pc_to_ic, 32'h10);

    // Jump while waiting on 0x10; late response 0xDEADBEEF is discarded.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    chk("jmp_qc", 32'(qc_m), 32'd0);
    chk("jmp_valid", 32'(m_bus.inst_valid), 32'd0);
    chk("jmp_pse", 32'(m_bus.pc_send_enable), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("drain_pse", 32'(m_bus.pc_send_enable), 32'd1);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    chk("drain_done_pse", 32'(m_bus.pc_send_enable), 32'd0);
    chk("drain_done_qc", 32'(qc_m), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("tgt_pse", 32'(m_bus.pc_send_enable), 32'd1);
    chk("tgt_pcic", m_bus.pc_to_ic, 32'h100);
    step(1'b1, f(32'h100), 1'b0, 1'b0, 32'h0);
    chk("tgt_qc", 32'(qc_m), 32'd1);
    chk("tgt_pti", m_bus.pc_to_issue, 32'h100);
    chk("tgt_inst", m_bus.inst_to_issue, f(32'h100));

    // Jump coinciding with a response and a pop.
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("j2_launch_pcic", m_bus.pc_to_ic, 32'h104);
    step(1'b1, f(32'h104), 1'b1, 1'b1, 32'h200);
    chk("j2_qc", 32'(qc_m), 32'd0);
    chk("j2_valid", 32'(m_bus.inst_valid), 32'd0);
    chk("j2_pse", 32'(m_bus.pc_send_enable), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("j2_next_pse", 32'(m_bus.pc_send_enable), 32'd1);
    chk("j2_next_pcic", m_bus.pc_to_ic, 32'h200);

    // Reset mid-WAIT, then a stray response right after reset.
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("mrst_pse", 32'(m_bus.pc_send_enable), 32'd0);
    chk("mrst_pcic", m_bus.pc_to_ic, 32'h0);
    chk("mrst_qc", 32'(qc_m), 32'd0);
    rst = 1'b0;
    step(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    chk("mrst_launch_pse", 32'(m_bus.pc_send_enable), 32'd1);
    chk("mrst_launch_qc", 32'(qc_m), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("mrst_stray_qc", 32'(qc_m), 32'd0);
    chk("mrst_stray_pse", 32'(m_bus.pc_send_enable), 32'd1);

    // Wrap: redirect near the top of the address space, 20 in-order issues.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF0);
    chk("wrap_jmp_qc", 32'(qc_m), 32'd0);
    jump_flag = 1'b0;
    m_bus.inst_get_ready = 1'b0;
    auto_ic = 1'b1;
    sb_on   = 1'b1;
    for (int c = 0; c < 400 && exp_k < 20; c++) begin
      m_bus.issue_ready = ($urandom_range(0, 1) == 1);
      cycle();
    end
    chk("wrap_issued", 32'(exp_k), 32'd20);
    sb_on = 1'b0;
    m_bus.issue_ready = 1'b0;

    // DEPTH=4 instance: fill with issue stalled, then release one pop.
    rst_s = 1'b0;
    for (int c = 0; c < 12; c++) cycle();
    chk("full_qc", 32'(qc_s), 32'd4);
    chk("full_pse", 32'(s_bus.pc_send_enable), 32'd0);
    chk("full_pcic", s_bus.pc_to_ic, 32'hC);
    chk("full_pti", s_bus.pc_to_issue, 32'h0);
    s_bus.issue_ready = 1'b1;
    cycle();
    s_bus.issue_ready = 1'b0;
    chk("resume_pse", 32'(s_bus.pc_send_enable), 32'd1);
    chk("resume_pcic", s_bus.pc_to_ic, 32'h10);
    chk("resume_qc", 32'(qc_s), 32'd3);
    chk("resume_pti", s_bus.pc_to_issue, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
